// File: rtl/noc_out_pkg.sv
// Shared types and constants for the router output-port controller.
// The flit type sits in the two MSBs of every flit.
package noc_out_pkg;

    typedef enum logic [1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Default flit geometry: 32-bit payload plus 2-bit type field on top.
    localparam int DEF_FLIT_W    = 34;
    localparam int FLIT_TYPE_MSB = DEF_FLIT_W - 1;
    localparam int FLIT_TYPE_LSB = DEF_FLIT_W - 2;

    // True for the flit types that close a packet.
    function automatic logic is_tail(input flit_type_t t);
        return (t == TAIL) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/noc_out_port_ctrl_chk.sv
// Protocol checker for the output-port controller: the arbiter grant must
// be one-hot (or empty) whenever the controller selects from it.
module noc_out_port_ctrl_chk #(
    parameter int N_INPUTS    = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                clk,
    input logic                arst,
    input logic                idle,
    input logic [N_INPUTS-1:0] grant
);

    // The lock timeout counter is 8 bits wide.
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
        $error("noc_out_port_ctrl: TIMEOUT_CYC must be within 1..255");
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (arst)
        idle |-> $onehot0(grant))
        else $error("noc_out_port_ctrl: multi-hot grant_i in IDLE, lowest index used");

endmodule

// File: rtl/noc_out_reg.sv
// One-stage valid/ready output register. The stage accepts a new flit
// whenever it is empty or its current flit is being taken downstream.
module noc_out_reg #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic             acc,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    assign acc       = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign dout      = data_r;

    // Advance the stage when it can accept; otherwise hold data stable.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (acc) begin
            valid_r <= load;
            if (load) begin
                data_r <= din;
            end
        end
    end

endmodule

// File: rtl/noc_out_port_ctrl.sv
// Router output-port controller behind the 2-input round-robin arbiter.
// Locks the winning input from HEAD to TAIL, forwards its flits through a
// one-stage output register and pulses update_o when a packet completes.
// Optional: define LOCK_TIMEOUT_EN to force release of a lock that has
// seen no flit for TIMEOUT_CYC cycles.
module noc_out_port_ctrl
    import noc_out_pkg::*;
#(
    parameter int N_INPUTS    = 2,
    parameter int FLIT_W      = DEF_FLIT_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [N_INPUTS-1:0]          in_valid_i,
    input  logic [N_INPUTS*FLIT_W-1:0]   in_flit_i,
    output logic [N_INPUTS-1:0]          in_ready_o,
    output logic [N_INPUTS-1:0]          req_o,
    input  logic [N_INPUTS-1:0]          grant_i,
    output logic                         update_o,
    output logic                         out_valid_o,
    output logic [FLIT_W-1:0]            out_flit_o,
    input  logic                         out_ready_i,
    output logic                         proto_err_o,
    output logic                         timeout_o
);

    localparam int SEL_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    state_t               state_r;
    logic [SEL_W-1:0]     sel_r;
    logic [SEL_W-1:0]     idx_s;
    logic                 have_s;
    logic [N_INPUTS-1:0]  req_s;
    logic [N_INPUTS-1:0]  rdy_s;
    logic [FLIT_W-1:0]    flit_s;
    flit_type_t           type_s;
    logic                 bad_s;
    logic                 hs_s;
    logic                 fwd_s;
    logic                 drop_s;
    logic                 end_s;
    logic                 acc_s;
    logic                 timeout_s;

    // Lowest set bit wins when the grant is not one-hot.
    function automatic logic [SEL_W-1:0] first_set(input logic [N_INPUTS-1:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            r = v[k] ? SEL_W'(k) : r;
        end
        return r;
    endfunction

    // Pick the source input, derive handshake, drop and packet-end events.
    always_comb begin
        idx_s  = '0;
        have_s = 1'b0;
        req_s  = '0;
        rdy_s  = '0;
        if (state_r == LOCKED) begin
            idx_s  = sel_r;
            have_s = 1'b1;
            req_s  = in_valid_i & (N_INPUTS'(1) << sel_r);
        end else begin
            idx_s  = first_set(grant_i);
            have_s = |grant_i;
            req_s  = in_valid_i;
        end
        flit_s = in_flit_i[int'(idx_s)*FLIT_W +: FLIT_W];
        type_s = flit_type_t'(flit_s[FLIT_W-1 -: 2]);
        // A packet may only open with HEAD or HEAD_TAIL; anything else is
        // swallowed so a stray flit cannot wedge its input.
        bad_s  = (state_r == IDLE) && ((type_s == BODY) || (type_s == TAIL));
        if (have_s) begin
            if (bad_s) begin
                rdy_s[idx_s] = 1'b1;
            end else begin
                rdy_s[idx_s] = acc_s;
            end
        end else begin
            rdy_s = '0;
        end
        hs_s   = have_s && in_valid_i[idx_s] && rdy_s[idx_s];
        fwd_s  = hs_s && !bad_s;
        drop_s = hs_s && bad_s;
        end_s  = fwd_s && is_tail(type_s);
    end

    // Packet lock state and the locked input index.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= IDLE;
            sel_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fwd_s && (type_s == HEAD)) begin
                        sel_r   <= idx_s;
                        state_r <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (end_s || timeout_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef LOCK_TIMEOUT_EN
    logic [7:0] idle_cnt_r;

    // A lock that sees no flit handshake for TIMEOUT_CYC cycles is released.
    assign timeout_s = (state_r == LOCKED) && !hs_s && (idle_cnt_r == 8'(TIMEOUT_CYC));

    // Count locked cycles without a handshake; cleared whenever not locked.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idle_cnt_r <= 8'd0;
        end else if ((state_r != LOCKED) || hs_s || timeout_s) begin
            idle_cnt_r <= 8'd0;
        end else begin
            idle_cnt_r <= idle_cnt_r + 8'd1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    noc_out_reg #(
        .WIDTH (FLIT_W)
    ) u_out_reg (
        .clk       (clk),
        .arst      (arst),
        .load      (fwd_s),
        .din       (flit_s),
        .out_ready (out_ready_i),
        .acc       (acc_s),
        .out_valid (out_valid_o),
        .dout      (out_flit_o)
    );

    noc_out_port_ctrl_chk #(
        .N_INPUTS    (N_INPUTS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_chk (
        .clk   (clk),
        .arst  (arst),
        .idle  (state_r == IDLE),
        .grant (grant_i)
    );

    // Handshake-side outputs are forced quiet while reset is applied.
    assign req_o       = arst ? '0 : req_s;
    assign in_ready_o  = arst ? '0 : rdy_s;
    assign update_o    = !arst && (end_s || timeout_s);
    assign proto_err_o = !arst && drop_s;
    assign timeout_o   = !arst && timeout_s;

endmodule

// File: tb/tb_noc_out_port_ctrl.sv
// Directed bench for noc_out_port_ctrl with a small round-robin arbiter model.
`timescale 1ns/1ps
module tb_noc_out_port_ctrl;
    import noc_out_pkg::*;

    localparam int FW = DEF_FLIT_W;

    logic          clk;
    logic          arst;
    logic [1:0]    in_valid;
    logic [FW-1:0] flit0;
    logic [FW-1:0] flit1;
    logic [1:0]    in_ready;
    logic [1:0]    req;
    logic [1:0]    grant;
    logic          update;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic          out_ready;
    logic          proto_err;
    logic          timeout;

    logic [1:0]    man_grant;
    logic [1:0]    arb_grant;
    logic          use_arb;
    logic          prio_r;

    int checks   = 0;
    int failures = 0;

    noc_out_port_ctrl dut (
        .clk         (clk),
        .arst        (arst),
        .in_valid_i  (in_valid),
        .in_flit_i   ({flit1, flit0}),
        .in_ready_o  (in_ready),
        .req_o       (req),
        .grant_i     (grant),
        .update_o    (update),
        .out_valid_o (out_valid),
        .out_flit_o  (out_flit),
        .out_ready_i (out_ready),
        .proto_err_o (proto_err),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign grant = use_arb ? arb_grant : man_grant;

    // Round-robin arbiter model: prio_r names the favoured input.
    always_comb begin
        arb_grant = 2'b00;
        if (req[prio_r]) begin
            arb_grant[prio_r] = 1'b1;
        end else if (req[!prio_r]) begin
            arb_grant[!prio_r] = 1'b1;
        end else begin
            arb_grant = 2'b00;
        end
    end

    // Rotate priority past the winner on every update pulse.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prio_r <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            prio_r <= ~grant[1];
        end
    end

    function automatic logic [FW-1:0] mk(input flit_type_t t, input int o, input int p, input int i);
        logic [FW-1:0] f;
        f = '0;
        f[FLIT_TYPE_MSB:FLIT_TYPE_LSB] = t;
        f[31:24] = 8'(o);
        f[23:16] = 8'(p);
        f[15:0]  = 16'(i);
        return f;
    endfunction

    function automatic flit_type_t ty3(input int i);
        return (i == 0) ? HEAD : ((i == 1) ? BODY : TAIL);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [FW-1:0] expq[$];
    int            sent[2];
    int            lock_m;
    int            got;
    int            seen;

    initial begin
        arst      = 1'b1;
        in_valid  = 2'b00;
        flit0     = '0;
        flit1     = '0;
        out_ready = 1'b1;
        man_grant = 2'b00;
        use_arb   = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_flit", out_flit, 34'd0);
        chk("rst_update", update, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        @(negedge clk);
        arst = 1'b0;

        // Single 3-flit packet on input 0, arbiter model in the loop.
        use_arb = 1'b1;
        @(negedge clk);
        in_valid = 2'b01; flit0 = mk(HEAD, 0, 0, 0);
        #1;
        chk("t1_req", req, 2'b01);
        chk("t1_rdy", in_ready, 2'b01);
        chk("t1_upd_head", update, 1'b0);
        @(negedge clk);
        chk("t1_ov_head", out_valid, 1'b1);
        chk("t1_of_head", out_flit, mk(HEAD, 0, 0, 0));
        flit0 = mk(BODY, 0, 0, 1);
        #1;
        chk("t1_upd_body", update, 1'b0);
        @(negedge clk);
        chk("t1_ov_body", out_valid, 1'b1);
        chk("t1_of_body", out_flit, mk(BODY, 0, 0, 1));
        flit0 = mk(TAIL, 0, 0, 2);
        #1;
        chk("t1_upd_tail", update, 1'b1);
        @(negedge clk);
        chk("t1_ov_tail", out_valid, 1'b1);
        chk("t1_of_tail", out_flit, mk(TAIL, 0, 0, 2));
        in_valid = 2'b00;
        #1;
        chk("t1_upd_after", update, 1'b0);
        @(negedge clk);
        chk("t1_ov_end", out_valid, 1'b0);

        // Both inputs stream two packets each; priority now favours input 1.
        for (int pk = 0; pk < 2; pk++) begin
            for (int oo = 1; oo >= 0; oo--) begin
                for (int i = 0; i < 3; i++) begin
                    expq.push_back(mk(ty3(i), oo, pk, i));
                end
            end
        end
        sent[0] = 0; sent[1] = 0; lock_m = 0; got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                got++;
                if (expq.size() > 0) begin
                    chk("t2_flit", out_flit, expq.pop_front());
                end else begin
                    chk("t2_extra_flit", out_valid, 1'b0);
                end
            end
            in_valid[0] = (sent[0] < 6);
            in_valid[1] = (sent[1] < 6);
            flit0 = mk(ty3(sent[0] % 3), 0, sent[0] / 3, sent[0] % 3);
            flit1 = mk(ty3(sent[1] % 3), 1, sent[1] / 3, sent[1] % 3);
            #1;
            if (lock_m != 0) begin
                chk("t2_req_single", $countones(req), 1);
            end
            for (int k = 0; k < 2; k++) begin
                if (in_valid[k] && in_ready[k]) begin
                    if ((sent[k] % 3) == 0) lock_m = 1;
                    sent[k]++;
                end
            end
            if (update) lock_m = 0;
        end
        chk("t2_out_count", got, 12);
        chk("t2_exp_left", expq.size(), 0);
        in_valid = 2'b00;
        use_arb  = 1'b0;

        // HEAD_TAIL on input 1: one flit, update in the same cycle, stays IDLE.
        @(negedge clk);
        in_valid = 2'b10; flit1 = mk(HEAD_TAIL, 1, 7, 0); man_grant = 2'b10;
        #1;
        chk("t3_rdy", in_ready, 2'b10);
        chk("t3_upd", update, 1'b1);
        @(negedge clk);
        chk("t3_ov", out_valid, 1'b1);
        chk("t3_of", out_flit, mk(HEAD_TAIL, 1, 7, 0));
        in_valid = 2'b01; flit0 = mk(HEAD, 0, 8, 0); man_grant = 2'b00;
        #1;
        chk("t3_req_idle", req, 2'b01);
        chk("t3_rdy_nogrant", in_ready, 2'b00);
        chk("t3_upd_after", update, 1'b0);
        @(negedge clk);
        chk("t3_ov_end", out_valid, 1'b0);
        in_valid = 2'b00;

        // Downstream stall of 5 cycles in the middle of a packet.
        @(negedge clk);
        in_valid = 2'b01; flit0 = mk(HEAD, 0, 9, 0); man_grant = 2'b01;
        #1;
        chk("t4_rdy_head", in_ready, 2'b01);
        @(negedge clk);
        chk("t4_of_head", out_flit, mk(HEAD, 0, 9, 0));
        man_grant = 2'b00; flit0 = mk(BODY, 0, 9, 1); out_ready = 1'b0;
        #1;
        chk("t4_rdy_stall", in_ready, 2'b00);
        chk("t4_req_locked", req, 2'b01);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("t4_hold_ov", out_valid, 1'b1);
            chk("t4_hold_of", out_flit, mk(HEAD, 0, 9, 0));
            chk("t4_hold_rdy", in_ready, 2'b00);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_rdy_release", in_ready, 2'b01);
        @(negedge clk);
        chk("t4_of_b1", out_flit, mk(BODY, 0, 9, 1));
        flit0 = mk(BODY, 0, 9, 2);
        #1;
        @(negedge clk);
        chk("t4_of_b2", out_flit, mk(BODY, 0, 9, 2));
        flit0 = mk(TAIL, 0, 9, 3);
        #1;
        chk("t4_upd_tail", update, 1'b1);
        @(negedge clk);
        chk("t4_of_tail", out_flit, mk(TAIL, 0, 9, 3));
        in_valid = 2'b00;
        #1;
        chk("t4_upd_after", update, 1'b0);
        @(negedge clk);
        chk("t4_ov_end", out_valid, 1'b0);

        // BODY flit while IDLE is swallowed and flagged.
        in_valid = 2'b01; flit0 = mk(BODY, 0, 3, 1); man_grant = 2'b01;
        #1;
        chk("t5_rdy", in_ready, 2'b01);
        chk("t5_proto", proto_err, 1'b1);
        chk("t5_upd", update, 1'b0);
        @(negedge clk);
        in_valid = 2'b00; man_grant = 2'b00;
        #1;
        chk("t5_ov", out_valid, 1'b0);
        chk("t5_proto_after", proto_err, 1'b0);

        // Reset in the middle of a locked packet with output valid.
        @(negedge clk);
        in_valid = 2'b01; flit0 = mk(HEAD, 0, 4, 0); man_grant = 2'b01;
        #1;
        chk("t6_rdy_head", in_ready, 2'b01);
        @(negedge clk);
        chk("t6_ov_pre", out_valid, 1'b1);
        man_grant = 2'b00; flit0 = mk(BODY, 0, 4, 1);
        #1;
        chk("t6_rdy_locked", in_ready, 2'b01);
        #2;
        arst = 1'b1;
        #1;
        chk("t6_rst_ov", out_valid, 1'b0);
        chk("t6_rst_of", out_flit, 34'd0);
        chk("t6_rst_upd", update, 1'b0);
        chk("t6_rst_rdy", in_ready, 2'b00);
        chk("t6_rst_proto", proto_err, 1'b0);
        chk("t6_rst_timeout", timeout, 1'b0);
        @(negedge clk);
        arst = 1'b0;
        in_valid = 2'b10; flit1 = mk(HEAD, 1, 5, 0); man_grant = 2'b10;
        #1;
        chk("t6_rdy_new", in_ready, 2'b10);
        @(negedge clk);
        chk("t6_ov_new", out_valid, 1'b1);
        chk("t6_of_new", out_flit, mk(HEAD, 1, 5, 0));
        man_grant = 2'b00; flit1 = mk(TAIL, 1, 5, 1);
        #1;
        chk("t6_req_new", req, 2'b10);
        chk("t6_upd_new", update, 1'b1);
        @(negedge clk);
        chk("t6_of_tail", out_flit, mk(TAIL, 1, 5, 1));
        in_valid = 2'b00;

`ifdef LOCK_TIMEOUT_EN
        // Abandoned lock: release on the 256th flit-less locked cycle.
        @(negedge clk);
        in_valid = 2'b01; flit0 = mk(HEAD, 0, 6, 0); man_grant = 2'b01;
        #1;
        @(negedge clk);
        in_valid = 2'b00; man_grant = 2'b00;
        seen = 0;
        for (int c = 1; (c <= 300) && (seen == 0); c++) begin
            #1;
            if (timeout) begin
                seen = 1;
                chk("to_cycle", c, 256);
                chk("to_upd", update, 1'b1);
            end
            @(negedge clk);
        end
        chk("to_seen", seen, 1);
        in_valid = 2'b01;
        #1;
        chk("to_after", timeout, 1'b0);
        chk("to_req_idle", req, 2'b01);
        in_valid = 2'b00;
`else
        chk("no_timeout", timeout, 1'b0);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_out_port_ctrl.md
Name: noc_out_port_ctrl

Overview:
- Output-port controller sitting directly downstream of the 2-input round-robin arbiter (`rr_arbiter`) in the router.
- Presents per-input valid flags to the arbiter as `req_o` and takes the winner from `grant_i`.
- Locks the winning input for a whole packet (head to tail) and forwards its flits through a one-stage output register.
- Pulses `update_o` on tail acceptance so the arbiter rotates priority.

Parameters:
- N_INPUTS, 2, number of competing input ports; must equal the arbiter request width.
- FLIT_W, 34, flit width including the 2-bit type field in bits [FLIT_W-1:FLIT_W-2].
- TIMEOUT_CYC, 255, idle cycles allowed while locked before forced release (only with LOCK_TIMEOUT_EN).

Ports:
- clk  in  1  single clock.
- arst  in  1  asynchronous, active-high reset.
- in_valid_i  in  N_INPUTS  per-input flit valid.
- in_flit_i  in  N_INPUTS*FLIT_W  packed flits; input k occupies [k*FLIT_W +: FLIT_W].
- in_ready_o  out  N_INPUTS  per-input accept.
- req_o  out  N_INPUTS  request vector to arbiter `req_i`.
- grant_i  in  N_INPUTS  one-hot grant from arbiter `grant_o`.
- update_o  out  1  to arbiter `update_i`; 1-cycle pulse.
- out_valid_o  out  1  registered output valid.
- out_flit_o  out  FLIT_W  registered output flit.
- out_ready_i  in  1  downstream accept.
- proto_err_o  out  1  1-cycle pulse when a non-head flit is dropped in IDLE.
- timeout_o  out  1  1-cycle pulse on forced release; tied 0 without the macro.

Behaviour:
- Reset (arst=1, asynchronous): state=IDLE, sel=0, out_valid_o=0, out_flit_o=0, update_o=0, proto_err_o=0, timeout_o=0. Reset asserted mid-packet abandons the packet; no update_o is generated.
- Flit type codes: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL.
- Output register accepts when `acc = !out_valid_o || out_ready_i`. Latency from input handshake to out_valid_o is 1 cycle. Full throughput is 1 flit/cycle.
- IDLE state:
  - req_o = in_valid_i.
  - The granted input g (one-hot grant_i) is handshaken when in_valid_i[g] && acc. in_ready_o[g]=acc; all other in_ready_o are 0.
  - HEAD flit: load the output register, sel<=g, go to LOCKED.
  - HEAD_TAIL flit: load the output register, assert update_o in the same cycle, stay in IDLE.
  - BODY or TAIL flit: in_ready_o[g]=1 regardless of acc, flit is dropped, proto_err_o=1, stay in IDLE.
  - grant_i==0: no transfer.
  - grant_i multi-hot: lowest set index is used and a simulation assertion fires.
- LOCKED state:
  - req_o = onehot(sel) & in_valid_i, so the arbiter grant equals sel while the mask is unchanged. grant_i is ignored for selection.
  - in_ready_o[sel]=acc; all others are 0.
  - BODY or HEAD flit: forwarded as-is, no state change.
  - TAIL or HEAD_TAIL flit: forwarded on handshake, update_o=1 in that same cycle, next state IDLE.
- update_o is combinational on the tail handshake cycle and is never asserted in any other cycle.
- Output hold: while out_valid_o && !out_ready_i, out_flit_o stays stable.
- Simultaneous events: a tail handshake and an output drain in the same cycle are legal. A new packet may win in the cycle after returning to IDLE.

Optional Feature:
- Macro: LOCK_TIMEOUT_EN.
- Defined:
  - 8-bit idle counter runs in LOCKED and clears on every handshake of sel.
  - When the counter reaches TIMEOUT_CYC, timeout_o=1 and update_o=1 for one cycle, then state goes to IDLE. No tail flit is synthesized.
  - The counter also clears on entry to IDLE.
- Undefined: no counter; timeout_o is tied to 0; LOCKED persists until a tail flit.

Decomposition:
- Package `noc_out_pkg`:
  - flit_type_t enum (HEAD, BODY, TAIL, HEAD_TAIL).
  - state_t enum (IDLE, LOCKED).
  - FLIT_TYPE_MSB/LSB localparams.
- One sub-module, `noc_out_reg`: the valid/ready output pipeline register, holding data and valid and exposing acc.

Test Plan:
- Input 0 sends HEAD,BODY,TAIL with input 1 idle, out_ready_i=1 -> out_valid_o high for 3 consecutive cycles starting 1 cycle after the first handshake; update_o pulses exactly once, on the TAIL handshake cycle.
- Both inputs continuously send 3-flit packets -> packets alternate 0,1,0,1 with no interleaving of flits; req_o shows a single bit while LOCKED.
- HEAD_TAIL on input 1 with grant_i=2'b10 -> one output flit, update_o pulses in the same cycle, state stays IDLE.
- out_ready_i held 0 for 5 cycles mid-packet -> out_flit_o stable, in_ready_o[sel]=0, no flit loss or duplication after release.
- BODY flit on input 0 while IDLE and granted -> in_ready_o[0]=1, proto_err_o pulses once, out_valid_o stays 0.
- arst asserted while LOCKED with out_valid_o=1 -> all outputs 0 immediately; after release, a HEAD on input 1 is accepted normally. With LOCK_TIMEOUT_EN, a HEAD with no further flits for 255 cycles -> timeout_o and update_o pulse together.
